// File: rtl/can_ctrl_frame_gen.sv
// CAN overload / active-error / passive-error frame generator with flag superposition,
// overload limiting and delimiter checking. Optional stuck-dominant detection: CTRL_STUCK_DOM_EN.
module can_ctrl_frame_gen #(
  parameter int unsigned FLAG_BITS    = 6,
  parameter int unsigned DELIM_BITS   = 8,
  parameter int unsigned MAX_OVERLOAD = 2,
  parameter int unsigned DOM_LIMIT    = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sample_point,
  input  logic             rx_bit,
  input  logic             sof,
  input  logic             req_overload,
  input  logic             req_error,
  input  logic             error_passive,
  output logic             tx_bit,
  output logic             busy,
  output logic [1:0]       frame_type,
  output logic [CNT_W-1:0] bit_counter,
  output logic             frame_done,
  output logic             overload_rejected,
  output logic             bit_error,
  output logic             form_error,
  output logic             stuck_dominant
);

  typedef enum logic [2:0] {StIdle, StFlag, StWait, StDelim, StDone} state_e;

  localparam logic [1:0]       FtOverload  = 2'b01;
  localparam logic [1:0]       FtActiveErr = 2'b10;
  localparam int unsigned      OvlW        = $clog2(MAX_OVERLOAD + 2);
  localparam logic [OvlW-1:0]  OvlMax      = OvlW'(MAX_OVERLOAD);
  localparam logic [CNT_W-1:0] FlagLast    = CNT_W'(FLAG_BITS - 1);
  localparam logic [CNT_W-1:0] DelimLast   = CNT_W'(DELIM_BITS - 1);
  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};

  if (FLAG_BITS >= 2**CNT_W || DELIM_BITS >= 2**CNT_W || DOM_LIMIT >= 2**CNT_W) begin : g_bad_cfg
    $error("can_ctrl_frame_gen: FLAG_BITS, DELIM_BITS and DOM_LIMIT must be < 2**CNT_W");
  end

  state_e           state_q, state_d;
  logic             tx_q, tx_d;
  logic [1:0]       ft_q, ft_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [OvlW-1:0]  ovl_q, ovl_d;
  logic             done_q, done_d;
  logic             rej_q, rej_d;
  logic             berr_q, berr_d;
  logic             ferr_q, ferr_d;
  logic             preempt, restart;
`ifdef CTRL_STUCK_DOM_EN
  localparam logic [CNT_W-1:0] DomLimit = CNT_W'(DOM_LIMIT);
  logic             stuck_q, stuck_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;
  // Only overload frames can be pre-empted by an error request.
  assign preempt = req_error && (ft_q == FtOverload) &&
                   (state_q inside {StFlag, StWait, StDelim});

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ft_d    = ft_q;
    cnt_d   = cnt_q;
    ovl_d   = sof ? '0 : ovl_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    berr_d  = 1'b0;
    ferr_d  = 1'b0;
    restart = 1'b0;
`ifdef CTRL_STUCK_DOM_EN
    stuck_d = 1'b0;
`endif
    if (preempt) begin
      restart = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_error) begin
            restart = 1'b1;
          end else if (req_overload) begin
            if (ovl_q < OvlMax) begin
              state_d = StFlag;
              ft_d    = FtOverload;
              cnt_d   = '0;
              tx_d    = 1'b0;
              ovl_d   = (sof ? '0 : ovl_q) + 1'b1;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        StFlag: begin
          if (sample_point) begin
            if (ft_q == FtActiveErr && rx_bit) berr_d = 1'b1;
            if (cnt_q == FlagLast) begin
              state_d = StWait;
              tx_d    = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StWait: begin
          tx_d = 1'b1;
          if (sample_point) begin
            if (!rx_bit) begin
              cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_inc;
`ifdef CTRL_STUCK_DOM_EN
              if (cnt_d == DomLimit) begin
                stuck_d = 1'b1;
                state_d = StFlag;
                ft_d    = FtActiveErr;
                cnt_d   = '0;
                tx_d    = 1'b0;
              end
`endif
            end else begin
              // The first recessive bit seen here is already delimiter bit 1.
              state_d = StDelim;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        StDelim: begin
          tx_d = 1'b1;
          if (sample_point) begin
            if (!rx_bit) begin
              ferr_d  = 1'b1;
              restart = 1'b1;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_q == DelimLast) begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    if (restart) begin
      state_d = StFlag;
      ft_d    = {1'b1, error_passive};
      cnt_d   = '0;
      tx_d    = error_passive;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !enable) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      ft_q    <= 2'b00;
      cnt_q   <= '0;
      ovl_q   <= '0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      berr_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef CTRL_STUCK_DOM_EN
      stuck_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ft_q    <= ft_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      berr_q  <= berr_d;
      ferr_q  <= ferr_d;
`ifdef CTRL_STUCK_DOM_EN
      stuck_q <= stuck_d;
`endif
    end
  end

  assign tx_bit            = tx_q;
  assign busy              = (state_q != StIdle);
  assign frame_type        = ft_q;
  assign bit_counter       = cnt_q;
  assign frame_done        = done_q;
  assign overload_rejected = rej_q;
  assign bit_error         = berr_q;
  assign form_error        = ferr_q;
`ifdef CTRL_STUCK_DOM_EN
  assign stuck_dominant    = stuck_q;
`else
  assign stuck_dominant    = 1'b0;
`endif

endmodule

// File: tb/tb_can_ctrl_frame_gen.sv
// Directed self-checking bench for can_ctrl_frame_gen: overload, error, pre-emption,
// delimiter form error, stuck-dominant and reset behaviour.
module tb_can_ctrl_frame_gen;

  logic       clock = 1'b0;
  logic       reset_n, enable, sample_point, rx_bit, sof;
  logic       req_overload, req_error, error_passive;
  logic       tx_bit, busy, frame_done, overload_rejected, bit_error, form_error, stuck_dominant;
  logic [1:0] frame_type;
  logic [3:0] bit_counter;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done, n_rej, n_berr, n_ferr, n_stuck;
  int          nbits;
  logic [31:0] tx_hist;

  can_ctrl_frame_gen dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .sample_point      (sample_point),
    .rx_bit            (rx_bit),
    .sof               (sof),
    .req_overload      (req_overload),
    .req_error         (req_error),
    .error_passive     (error_passive),
    .tx_bit            (tx_bit),
    .busy              (busy),
    .frame_type        (frame_type),
    .bit_counter       (bit_counter),
    .frame_done        (frame_done),
    .overload_rejected (overload_rejected),
    .bit_error         (bit_error),
    .form_error        (form_error),
    .stuck_dominant    (stuck_dominant)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_done = 0; n_rej = 0; n_berr = 0; n_ferr = 0; n_stuck = 0; tx_hist = '0;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (frame_done)        n_done++;
    if (overload_rejected) n_rej++;
    if (bit_error)         n_berr++;
    if (form_error)        n_ferr++;
    if (stuck_dominant)    n_stuck++;
  endtask

  // One bit time: sample point on the first clock, three idle clocks after.
  task automatic bit_time(input logic rx);
    tx_hist      = {tx_hist[30:0], tx_bit};
    rx_bit       = rx;
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_bits(input int n, input logic rx);
    for (int i = 0; i < n; i++) bit_time(rx);
  endtask

  task automatic finish_recessive(input int max_bits, output int n);
    int start;
    start = n_done;
    n = 0;
    while (n < max_bits && n_done == start) begin
      bit_time(1'b1);
      n++;
    end
  endtask

  task automatic pulse_req_overload();
    req_overload = 1'b1;
    tick();
    req_overload = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; sample_point = 1'b0; rx_bit = 1'b1; sof = 1'b0;
    req_overload = 1'b0; req_error = 1'b0; error_passive = 1'b0;
    clear_counts();
    repeat (3) tick();
    check("rst_tx", tx_bit, 1);
    check("rst_busy", busy, 0);
    check("rst_ftype", frame_type, 0);
    check("rst_cnt", bit_counter, 0);
    check("rst_pulses", {frame_done, overload_rejected, bit_error, form_error, stuck_dominant}, 0);
    reset_n = 1'b1;
    tick();

    // Overload frame with bus echoing tx.
    clear_counts();
    pulse_req_overload();
    check("t1_busy", busy, 1);
    check("t1_ftype", frame_type, 1);
    check("t1_tx", tx_bit, 0);
    check("t1_cnt", bit_counter, 0);
    send_bits(6, 1'b0);
    check("t1_wait_tx", tx_bit, 1);
    finish_recessive(20, nbits);
    check("t1_bits", 6 + nbits, 14);
    check("t1_txhist", tx_hist[13:0], 32'h00ff);
    check("t1_done", n_done, 1);
    check("t1_ftype_hold", frame_type, 1);
    check("t1_idle", busy, 0);

    // Overload with 3 superposed dominant bits after the flag.
    clear_counts();
    pulse_req_overload();
    send_bits(6, 1'b0);
    send_bits(3, 1'b0);
    check("t2_wait_cnt", bit_counter, 3);
    finish_recessive(20, nbits);
    check("t2_bits", 9 + nbits, 17);
    check("t2_berr", n_berr, 0);

    // Third overload without sof is refused; after sof it is accepted.
    clear_counts();
    pulse_req_overload();
    check("t3_rej", n_rej, 1);
    check("t3_busy", busy, 0);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    pulse_req_overload();
    check("t3_accept", busy, 1);
    check("t3_rej_once", n_rej, 1);

    // req_overload ignored mid-frame, then req_error pre-empts in DELIM bit 3.
    send_bits(6, 1'b0);
    send_bits(2, 1'b1);
    check("t4_delim_cnt", bit_counter, 2);
    pulse_req_overload();
    check("t4_ovl_ignored", n_rej, 1);
    error_passive = 1'b0;
    req_error = 1'b1;
    tick();
    req_error = 1'b0;
    check("t4_ftype", frame_type, 2);
    check("t4_tx", tx_bit, 0);
    check("t4_cnt", bit_counter, 0);
    check("t4_busy", busy, 1);

    // Dominant bit at DELIM bit 4 of the error frame restarts the flag.
    clear_counts();
    send_bits(6, 1'b0);
    send_bits(3, 1'b1);
    bit_time(1'b0);
    check("t5_ferr", n_ferr, 1);
    check("t5_ftype", frame_type, 2);
    check("t5_cnt", bit_counter, 0);
    check("t5_tx", tx_bit, 0);
    check("t5_no_done", n_done, 0);
    bit_time(1'b1);
    check("t5_berr", n_berr, 1);
    check("t5_flag_cont", bit_counter, 1);

    // Reset for one clock mid-flag aborts the frame.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t7_tx", tx_bit, 1);
    check("t7_busy", busy, 0);
    check("t7_ftype", frame_type, 0);
    repeat (4) tick();
    check("t7_no_done", n_done, 0);

    // Both requests: passive error wins; enable=0 clears.
    clear_counts();
    error_passive = 1'b1;
    req_error = 1'b1;
    req_overload = 1'b1;
    tick();
    req_error = 1'b0;
    req_overload = 1'b0;
    check("pe_ftype", frame_type, 3);
    check("pe_tx", tx_bit, 1);
    bit_time(1'b1);
    check("pe_no_berr", n_berr, 0);
    check("pe_cnt", bit_counter, 1);
    error_passive = 1'b0;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("en_busy", busy, 0);
    check("en_ftype", frame_type, 0);
    check("en_cnt", bit_counter, 0);

    // Eight dominant bits while waiting for the delimiter.
    clear_counts();
    pulse_req_overload();
    send_bits(6, 1'b0);
    send_bits(8, 1'b0);
`ifdef CTRL_STUCK_DOM_EN
    check("t6_stuck", n_stuck, 1);
    check("t6_ftype", frame_type, 2);
    check("t6_tx", tx_bit, 0);
    check("t6_cnt", bit_counter, 0);
`else
    check("t6_stuck", n_stuck, 0);
    check("t6_ftype", frame_type, 1);
    check("t6_tx", tx_bit, 1);
    check("t6_cnt", bit_counter, 8);
`endif
    check("t6_busy", busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
